// File: rtl/modcnt_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter family.
package modcnt_pkg;

  localparam int unsigned MOD_MIN = 2;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // A modulus is usable when it lies between MOD_MIN and 2^width inclusive.
  // The upper bound lets the counter run as a plain binary counter.
  function automatic logic legal_mod(input logic [31:0] val, input int width);
    logic [32:0] limit;
    limit = 33'd1 << width;
    return (val >= 32'(MOD_MIN)) && ({1'b0, val} <= limit);
  endfunction

endpackage

// File: rtl/modcnt_wrap_tracker.sv
// Saturating counter of wrap events, used by mod_counter_ud when the
// MODCNT_WRAP_COUNT_EN build option is enabled.
module modcnt_wrap_tracker #(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt
);

  // Count wraps, stick at all ones, and clear with the counter's own clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_cnt <= '0;
    end else if (clr) begin
      wrap_cnt <= '0;
    end else if (wrap && (wrap_cnt != '1)) begin
      wrap_cnt <= wrap_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mod_counter_ud.sv
// Modulo-N up/down counter with clear, parallel load, runtime modulus,
// wrap/saturate mode, terminal count and carry outputs.
// Build option: define MODCNT_WRAP_COUNT_EN to add the WRAP_W parameter and
// the saturating wrap_cnt output.
module mod_counter_ud
  import modcnt_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MOD_DEFAULT = 10
`ifdef MODCNT_WRAP_COUNT_EN
  ,
  parameter int WRAP_W      = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             mod_wr,
  input  logic [WIDTH:0]   mod_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH:0]   modulus,
  output logic             tc,
  output logic             carry,
  output logic             mod_err
`ifdef MODCNT_WRAP_COUNT_EN
  ,
  output logic [WRAP_W-1:0] wrap_cnt
`endif
);

  localparam int MODW = WIDTH + 1;

  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] new_top;
  logic [WIDTH-1:0] top_next;
  logic             mod_ok;
  logic [WIDTH-1:0] step_count;
  logic             step_carry;
  logic [WIDTH-1:0] next_count;
  logic             next_carry;

  // Bounds derived from the current modulus and from a modulus being written
  // this edge; a legal modulus is at least 2, so top always fits in WIDTH bits.
  always_comb begin
    top      = WIDTH'(modulus - MODW'(1));
    new_top  = WIDTH'(mod_val - MODW'(1));
    mod_ok   = mod_wr && legal_mod(32'(mod_val), WIDTH);
    top_next = mod_ok ? new_top : top;
    tc       = ((up_dn == DIR_UP) && (count == top)) ||
               ((up_dn != DIR_UP) && (count == '0));
  end

  // Candidate count for a plain enable step, including wrap and saturation.
  always_comb begin
    step_count = count;
    step_carry = 1'b0;
    if (en) begin
      if (up_dn == DIR_UP) begin
        if (count < top) begin
          step_count = count + 1'b1;
        end else if (sat_mode != MODE_SAT) begin
          step_count = '0;
          step_carry = 1'b1;
        end
      end else begin
        if (count != '0) begin
          step_count = count - 1'b1;
        end else if (sat_mode != MODE_SAT) begin
          step_count = top;
          step_carry = 1'b1;
        end
      end
    end
  end

  // Resolve clear, load and modulus clamping on top of the enable step;
  // a clamp replaces the step, so it never produces a carry.
  always_comb begin
    next_count = step_count;
    next_carry = step_carry;
    if (clr) begin
      next_count = '0;
      next_carry = 1'b0;
    end else if (load) begin
      next_count = (load_val > top_next) ? top_next : load_val;
      next_carry = 1'b0;
    end else if (mod_ok && (step_count >= new_top)) begin
      next_count = new_top;
      next_carry = 1'b0;
    end
  end

  // State registers: count, modulus and the single-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      modulus <= MODW'(MOD_DEFAULT);
      carry   <= 1'b0;
      mod_err <= 1'b0;
    end else begin
      count   <= next_count;
      carry   <= next_carry;
      mod_err <= mod_wr && !mod_ok;
      if (mod_ok) begin
        modulus <= mod_val;
      end
    end
  end

`ifdef MODCNT_WRAP_COUNT_EN
  modcnt_wrap_tracker #(
    .WRAP_W (WRAP_W)
  ) u_wrap_tracker (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .wrap     (next_carry),
    .wrap_cnt (wrap_cnt)
  );
`else
  // Without the build option there is no wrap tracking at all.
`endif

endmodule
